// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, integer saturation limits,
// and the stage-1 payload of the float-to-int pipeline.
package fpu_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned INT_W    = 32;

    localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    // Exponent at which the mantissa LSB has weight 1.
    localparam int unsigned MANT_POINT_EXP = EXP_BIAS + FRAC_W;
    // Smallest exponent whose magnitude can round to a nonzero integer (0.5).
    localparam int unsigned HALF_EXP       = EXP_BIAS - 1;
    // Smallest exponent whose magnitude is at least 2^31.
    localparam int unsigned OVF_EXP        = EXP_BIAS + INT_W - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

    typedef struct packed {
        logic             sign;
        logic [INT_W-1:0] mag;
        logic             rnd;
        logic             ovf;
        logic             nan;
    } ftoi_s1_t;

endpackage

// File: rtl/ftoi_align.sv
// Combinational mantissa aligner for float-to-int conversion.
// Ports:
//   a      binary32 operand
//   mag_c  truncated integer magnitude (valid when ovf_c is clear)
//   rnd_c  first bit below the integer LSB (round-half bit)
//   ovf_c  |a| >= 2^31 (also set for inf and NaN)
//   nan_c  a is a NaN
module ftoi_align
    import fpu_pkg::*;
(
    input  logic [INT_W-1:0] a,
    output logic [INT_W-1:0] mag_c,
    output logic             rnd_c,
    output logic             ovf_c,
    output logic             nan_c
);

    float32_t                op;
    logic     [FRAC_W:0]     mant;
    logic     [FRAC_W:0]     rtmp;
    logic     [2:0]          lsh;
    logic     [4:0]          rsh;

    assign op = a;

    // Zero and denormal exponents fall below HALF_EXP, so they need no
    // separate case: the magnitude comes out as zero.
    always_comb begin
        mant  = {1'b1, op.frac};
        lsh   = 3'(op.exp - EXP_W'(MANT_POINT_EXP));
        rsh   = 5'(EXP_W'(MANT_POINT_EXP) - op.exp);
        // Shift one short so the last bit shifted out lands in rtmp[0].
        rtmp  = mant >> (rsh - 5'd1);
        mag_c = '0;
        rnd_c = 1'b0;
        ovf_c = (op.exp >= EXP_W'(OVF_EXP));
        nan_c = (op.exp == '1) && (op.frac != '0);
        if (!ovf_c && (op.exp >= EXP_W'(MANT_POINT_EXP))) begin
            mag_c = INT_W'(mant) << lsh;
        end else if (op.exp >= EXP_W'(HALF_EXP) && (op.exp < EXP_W'(MANT_POINT_EXP))) begin
            mag_c = INT_W'(rtmp >> 1);
            rnd_c = rtmp[0];
        end
    end

endmodule

// File: rtl/ftoi_pipeline.sv
// Two-stage pipelined binary32 to signed int32 converter (ftoi).
// Round to nearest, ties away from zero; NaN and positive overflow saturate
// to INT_MAX, negative overflow saturates to INT_MIN.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset, clears both stages
//   a    binary32 operand, sampled every cycle
//   c    int32 result, registered, two edges after a is sampled
module ftoi_pipeline
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] a,
    output logic [INT_W-1:0] c
);

    ftoi_s1_t         s1;
    logic [INT_W-1:0] mag_c;
    logic             rnd_c;
    logic             ovf_c;
    logic             nan_c;
    logic [INT_W-1:0] sum_c;
    logic [INT_W-1:0] res_c;

    ftoi_align u_align (
        .a     (a),
        .mag_c (mag_c),
        .rnd_c (rnd_c),
        .ovf_c (ovf_c),
        .nan_c (nan_c)
    );

    // Stage 1: register aligned magnitude and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
        end else begin
            s1.sign <= a[INT_W-1];
            s1.mag  <= mag_c;
            s1.rnd  <= rnd_c;
            s1.ovf  <= ovf_c;
            s1.nan  <= nan_c;
        end
    end

    // Stage 2 logic: round, saturate, apply sign. The rounded sum cannot
    // reach 2^31 on the non-overflow path, so no carry check is needed.
    always_comb begin
        sum_c = s1.mag + INT_W'(s1.rnd);
        res_c = s1.sign ? (~sum_c + INT_W'(1)) : sum_c;
        if (s1.nan) begin
            res_c = INT_MAX;
        end else if (s1.ovf) begin
            res_c = s1.sign ? INT_MIN : INT_MAX;
        end
    end

    // Stage 2: result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c <= '0;
        end else begin
            c <= res_c;
        end
    end

endmodule

// File: tb/tb_ftoi_pipeline.sv
// Self-checking bench for ftoi_pipeline: directed latency, rounding,
// saturation and special-value cases, random regression against an
// arithmetic reference model, and reset behaviour during traffic.
module tb_ftoi_pipeline;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] c;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];
    bit   [1:0]  vpipe;

    ftoi_pipeline dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor(|x| + 0.5) computed as ((2|x| truncated) + 1) >> 1.
    function automatic logic [31:0] ref_ftoi(input logic [31:0] v);
        int          ei;
        logic [63:0] m;
        logic [63:0] r;
        ei = int'(v[30:23]);
        if (ei == 255 && v[22:0] != 23'd0) return 32'h7FFF_FFFF;
        m = {40'd0, 1'b1, v[22:0]};
        if (ei >= 160)      r = 64'h1_0000_0000;
        else if (ei < 126)  r = 64'd0;
        else if (ei >= 149) r = ((m << (ei - 149)) + 64'd1) >> 1;
        else                r = ((m >> (149 - ei)) + 64'd1) >> 1;
        if (r >= 64'h8000_0000) return v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return v[31] ? 32'(-r) : r[31:0];
    endfunction

    // One cycle: at the falling edge, report whether the result for an
    // operand driven two cycles earlier is due, then drive the next operand.
    task automatic step(input logic [31:0] v, input logic [31:0] exp_in, input bit drv,
                        output bit due, output logic [31:0] exp_out);
        @(negedge clk);
        due     = vpipe[1];
        exp_out = 32'd0;
        if (due) exp_out = exp_q.pop_front();
        vpipe[1] = vpipe[0];
        vpipe[0] = drv;
        if (drv) begin
            a = v;
            exp_q.push_back(exp_in);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        a     = 32'h4040_0000;
        vpipe = '0;
        #1;
        n_total++;
        if (c !== 32'd0) $display("FAIL reset_async c=%h want=%h", c, 32'd0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (c !== 32'd0) $display("FAIL reset_hold cycle=%0d c=%h want=%h", i, c, 32'd0);
            else n_pass++;
        end
        @(negedge clk);
        a   = 32'd0;
        rst = 1'b1;
    endtask

    task automatic test_latency();
        logic [31:0] vals[6] = '{32'h0, 32'h3F80_0000, 32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        logic [31:0] exps[6] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd2, 32'd3};
        bit          due;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(vals[i], exps[i], 1'b1, due, e);
            else       step(32'd0, 32'd0, 1'b0, due, e);
            if (due) begin
                n_total++;
                if (c !== e) $display("FAIL latency idx=%0d c=%h want=%h", i - 2, c, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vals[5] = '{32'h4020_0000, 32'hBFC0_0000, 32'h3F00_0000, 32'h3EFF_FFFF, 32'h3FBF_FFFF};
        logic [31:0] exps[5] = '{32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        bit          due;
        logic [31:0] e;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) step(vals[i], exps[i], 1'b1, due, e);
            else       step(32'd0, 32'd0, 1'b0, due, e);
            if (due) begin
                n_total++;
                if (c !== e) $display("FAIL rounding idx=%0d c=%h want=%h", i - 2, c, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vals[6] = '{32'h7367_26E6, 32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h4EFF_FFFF, 32'h7F80_0000};
        logic [31:0] exps[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FF80, 32'h7FFF_FFFF};
        bit          due;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(vals[i], exps[i], 1'b1, due, e);
            else       step(32'd0, 32'd0, 1'b0, due, e);
            if (due) begin
                n_total++;
                if (c !== e) $display("FAIL saturation idx=%0d c=%h want=%h", i - 2, c, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] vals[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFC0_0000, 32'hBE80_0000};
        logic [31:0] exps[5] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
        bit          due;
        logic [31:0] e;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) step(vals[i], exps[i], 1'b1, due, e);
            else       step(32'd0, 32'd0, 1'b0, due, e);
            if (due) begin
                n_total++;
                if (c !== e) $display("FAIL specials idx=%0d c=%h want=%h", i - 2, c, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        bit          due;
        logic [31:0] e;
        logic [31:0] v;
        int          errs = 0;
        int          n    = 0;
        // Back-to-back random stream, then slow stream with each operand held 8 cycles.
        for (int i = 0; i < 3000 + 200 * 8 + 2; i++) begin
            if (i < 3000 || (i < 3000 + 1600 && ((i - 3000) % 8) == 0)) begin
                v = $urandom;
                if ($urandom_range(1, 0) == 1) v[30:23] = 8'($urandom_range(165, 118));
            end
            if (i < 3000 + 1600) step(v, ref_ftoi(v), 1'b1, due, e);
            else                 step(32'd0, 32'd0, 1'b0, due, e);
            if (due) begin
                n_total++;
                n++;
                if (c !== e) begin
                    errs++;
                    if (errs <= 10) $display("FAIL random n=%0d c=%h want=%h", n, c, e);
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [31:0] vals[4] = '{32'h4040_0000, 32'hC0A0_0000, 32'h4000_0000, 32'h40E0_0000};
        logic [31:0] exps[4] = '{32'd3, 32'hFFFF_FFFB, 32'd2, 32'd7};
        bit          due;
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            step(vals[i], exps[i], 1'b1, due, e);
            if (due) begin
                n_total++;
                if (c !== e) $display("FAIL midstream_pre idx=%0d c=%h want=%h", i - 2, c, e);
                else n_pass++;
            end
        end
        // Assert reset mid-cycle while c holds a nonzero result.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_total++;
        if (c !== 32'd0) $display("FAIL midstream_async c=%h want=%h", c, 32'd0);
        else n_pass++;
        exp_q.delete();
        vpipe = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (c !== 32'd0) $display("FAIL midstream_hold cycle=%0d c=%h want=%h", i, c, 32'd0);
            else n_pass++;
        end
        // Release with 7.0 still on a; it is sampled after release.
        @(negedge clk);
        rst      = 1'b1;
        vpipe[0] = 1'b1;
        exp_q.push_back(32'd7);
        @(posedge clk);
        #1;
        n_total++;
        if (c !== 32'd0) $display("FAIL midstream_refill c=%h want=%h", c, 32'd0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) step(32'h4100_0000, 32'd8, 1'b1, due, e);
            else       step(32'd0, 32'd0, 1'b0, due, e);
            if (due) begin
                n_total++;
                if (c !== e) $display("FAIL midstream_post idx=%0d c=%h want=%h", i, c, e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_specials();
        test_random();
        test_midstream_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
